// File: rtl/calc1_port_responder.sv
// calc1_port_responder
//   Responder end of one calc1 port. Accepts a command with operand1, takes
//   operand2 on the following cycle, runs add/sub/shl/shr and presents a
//   one-cycle response code plus result after a fixed latency.
//
// Parameters
//   DATA_W    operand/result width; buses are [0:DATA_W-1], bit DATA_W-1 is LSB
//   RESP_LAT  edges from operand2 capture to response load, minus 1 (>= 1)
//
// Ports
//   c_clk     clock, rising edge
//   reset     synchronous, active-low
//   req_cmd   command; nonzero in IDLE starts a request
//   req_data  operand1 with the command, operand2 on the next cycle
//   out_resp  0 none, 1 success, 2 overflow/underflow/invalid command
//   out_data  result while out_resp != 0, otherwise 0
//   busy      high from command acceptance until the response clears
module calc1_port_responder #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RESP_LAT = 2
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:3]        req_cmd,
  input  logic [0:DATA_W-1] req_data,
  output logic [0:1]        out_resp,
  output logic [0:DATA_W-1] out_data,
  output logic              busy
);

  localparam int unsigned CNT_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OP2,
    S_EXEC,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic [0:3]        cmd_q, cmd_d;
  logic [0:DATA_W-1] op1_q, op1_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [0:1]        pend_resp_q, pend_resp_d;
  logic [0:DATA_W-1] pend_data_q, pend_data_d;
  logic [0:1]        out_resp_q, out_resp_d;
  logic [0:DATA_W-1] out_data_q, out_data_d;
  logic              busy_q, busy_d;

  // Result of the latched command against operand2 as presented on req_data;
  // only meaningful in S_OP2, where it is captured.
  logic [DATA_W:0]   sum;
  logic [4:0]        shamt;
  logic [0:1]        res_code;
  logic [0:DATA_W-1] res_data;

  always_comb begin
    sum      = {1'b0, op1_q} + {1'b0, req_data};
    shamt    = req_data[DATA_W-5:DATA_W-1];
    res_code = RESP_ERR;
    res_data = '0;
    case (cmd_q)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          res_code = RESP_OK;
          res_data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (req_data <= op1_q) begin
          res_code = RESP_OK;
          res_data = op1_q - req_data;
        end
      end
      CMD_SHL: begin
        res_code = RESP_OK;
        res_data = op1_q << shamt;
      end
      CMD_SHR: begin
        res_code = RESP_OK;
        res_data = op1_q >> shamt;
      end
      default: begin
        res_code = RESP_ERR;
        res_data = '0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    op1_d       = op1_q;
    cnt_d       = cnt_q;
    pend_resp_d = pend_resp_q;
    pend_data_d = pend_data_q;
    out_resp_d  = out_resp_q;
    out_data_d  = out_data_q;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (req_cmd != '0) begin
          cmd_d   = req_cmd;
          op1_d   = req_data;
          busy_d  = 1'b1;
          state_d = S_OP2;
        end
      end
      S_OP2: begin
        pend_resp_d = res_code;
        pend_data_d = res_data;
        cnt_d       = CNT_W'(RESP_LAT - 1);
        if (RESP_LAT == 1) begin
          out_resp_d = res_code;
          out_data_d = res_data;
          state_d    = S_RESP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q == CNT_W'(1)) begin
          out_resp_d = pend_resp_q;
          out_data_d = pend_data_q;
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        out_resp_d = RESP_NONE;
        out_data_d = '0;
        busy_d     = 1'b0;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      op1_q       <= '0;
      cnt_q       <= '0;
      pend_resp_q <= RESP_NONE;
      pend_data_q <= '0;
      out_resp_q  <= RESP_NONE;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      op1_q       <= op1_d;
      cnt_q       <= cnt_d;
      pend_resp_q <= pend_resp_d;
      pend_data_q <= pend_data_d;
      out_resp_q  <= out_resp_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  assign out_resp = out_resp_q;
  assign out_data = out_data_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_calc1_port_responder.sv
module tb_calc1_port_responder;

  logic        c_clk;
  logic        reset;
  logic [0:3]  req_cmd;
  logic [0:31] req_data;
  logic [0:1]  out_resp;
  logic [0:31] out_data;
  logic        busy;

  int tests = 0;
  int fails = 0;

  calc1_port_responder #(
    .DATA_W  (32),
    .RESP_LAT(2)
  ) dut (
    .c_clk   (c_clk),
    .reset   (reset),
    .req_cmd (req_cmd),
    .req_data(req_data),
    .out_resp(out_resp),
    .out_data(out_data),
    .busy    (busy)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction at the earliest legal rate; leaves the DUT in IDLE.
  task automatic do_op(input string tag, input logic [3:0] cmd, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed);
    req_cmd  = cmd;
    req_data = a;
    tick();
    check({tag, " busy@E1"}, 64'(busy), 64'd1);
    check({tag, " resp@E1"}, 64'(out_resp), 64'd0);
    req_cmd  = 4'($urandom_range(0, 15));
    req_data = b;
    tick();
    check({tag, " resp@E2"}, 64'(out_resp), 64'd0);
    check({tag, " data@E2"}, 64'(out_data), 64'd0);
    req_cmd  = '0;
    req_data = $urandom;
    tick();
    check({tag, " resp"}, 64'(out_resp), 64'(er));
    check({tag, " data"}, 64'(out_data), 64'(ed));
    check({tag, " busy@resp"}, 64'(busy), 64'd1);
    tick();
    check({tag, " resp clear"}, 64'(out_resp), 64'd0);
    check({tag, " data clear"}, 64'(out_data), 64'd0);
    check({tag, " busy clear"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset    = 1'b0;
    req_cmd  = '0;
    req_data = '0;
    tick();
    tick();
    check("rst resp", 64'(out_resp), 64'd0);
    check("rst data", 64'(out_data), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    reset = 1'b1;
    tick();

    // add
    do_op("add basic", 4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000);
    do_op("add carry", 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
    do_op("add big",   4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE);

    // sub
    do_op("sub under", 4'd2, 32'd1,   32'd15, 2'd2, 32'd0);
    do_op("sub equal", 4'd2, 32'd15,  32'd15, 2'd1, 32'd0);
    do_op("sub plain", 4'd2, 32'd100, 32'd58, 2'd1, 32'd42);

    // shifts
    for (int k = 1; k <= 30; k++) begin
      do_op($sformatf("shl k=%0d", k), 4'd5, 32'd1, 32'(k), 2'd1, 32'd1 << k);
    end
    do_op("shl mask",  4'd5, 32'd1,          32'h0000_0021, 2'd1, 32'd2);
    do_op("shl drop",  4'd5, 32'hC000_0001,  32'd1,         2'd1, 32'h8000_0002);
    do_op("shr 31",    4'd6, 32'h8000_0000,  32'd31,        2'd1, 32'd1);
    do_op("shr mask",  4'd6, 32'h0000_00F0,  32'hFFFF_FFE4, 2'd1, 32'h0000_000F);

    // invalid commands
    do_op("cmd3",  4'd3,  32'd1, 32'd1, 2'd2, 32'd0);
    do_op("cmd4",  4'd4,  32'd1, 32'd1, 2'd2, 32'd0);
    do_op("cmd15", 4'd15, 32'd7, 32'd9, 2'd2, 32'd0);

    // cmd 0 never starts a request
    for (int i = 0; i < 10; i++) begin
      req_cmd  = '0;
      req_data = $urandom;
      tick();
      check($sformatf("idle resp %0d", i), 64'(out_resp), 64'd0);
      check($sformatf("idle busy %0d", i), 64'(busy), 64'd0);
    end

    // reset during EXEC discards the request
    req_cmd  = 4'd1;
    req_data = 32'd1;
    tick();
    req_cmd  = '0;
    req_data = 32'd2;
    tick();
    reset = 1'b0;
    tick();
    check("rst exec resp", 64'(out_resp), 64'd0);
    check("rst exec busy", 64'(busy), 64'd0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post rst resp %0d", i), 64'(out_resp), 64'd0);
      check($sformatf("post rst busy %0d", i), 64'(busy), 64'd0);
    end
    do_op("after rst", 4'd1, 32'd3, 32'd4, 2'd1, 32'd7);

    // commands while busy are dropped
    req_cmd  = 4'd1;
    req_data = 32'd5;
    tick();
    req_cmd  = 4'd1;
    req_data = 32'd6;
    tick();
    req_cmd  = 4'd2;
    req_data = 32'd100;
    tick();
    check("busy drop resp", 64'(out_resp), 64'd1);
    check("busy drop data", 64'(out_data), 64'd11);
    req_cmd  = 4'd6;
    req_data = 32'd1;
    tick();
    check("resp cmd ign resp", 64'(out_resp), 64'd0);
    check("resp cmd ign busy", 64'(busy), 64'd0);
    req_cmd = '0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("single resp %0d", i), 64'(out_resp), 64'd0);
      check($sformatf("single busy %0d", i), 64'(busy), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
